pwm_sequencer: RTL

- Controller that sequences the duty value of the existing `pwm` generator to produce a breathing pattern: ramp up, hold high, ramp down, hold low.
- Rotates the breathing cycle across NUM_CH LED channels using a one-hot channel select. The select drives the per-channel output muxing at top level.
- Sits between top-level control (buttons or register) and one shared `pwm` instance: `duty` feeds pwm `value`, and `ch_sel` gates pwm `out` onto one LED.

---
 rtl/pwm_seq_pkg.sv | 11 +
 rtl/pwm_sequencer_tick_gen.sv | 17 +
 rtl/pwm_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared state encoding, default parameters and MAXV helper for the pwm sequencer
package pwm_seq_pkg;
  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO} state_t;
  localparam int DEF_BITS = 9;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TICK_DIV = 12000;
  localparam int DEF_HOLD_W = 8;
  function automatic int maxv(input int bits);
    return (1 << bits) - 1;
  endfunction
endpackage

// File: rtl/pwm_sequencer_tick_gen.sv
// tick_gen: prescaler emitting a one-clk tick every TICK_DIV clks while enabled
module tick_gen #(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || !en) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: breathing-pattern duty sequencer rotating across one-hot LED channels
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [BITS-1:0]   step,
  input  logic [HOLD_W-1:0] hold,
  output logic [BITS-1:0]   duty,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              busy,
  output logic              cycle_done
);
  localparam logic [BITS-1:0] MAXV = BITS'(maxv(BITS));
  state_t state, state_n;
  logic [BITS-1:0] duty_n, step_l, step_l_n, up, down, step_in;
  logic [HOLD_W-1:0] hold_l, hold_l_n, hold_cnt, hold_cnt_n;
  logic [NUM_CH-1:0] ch_sel_n;
  logic [BITS:0] sum;
  logic stop_p, stop_p_n, done_n, tick, hold_end;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .en(busy), .tick(tick));
  assign busy = state != IDLE;
  assign sum = {1'b0, duty} + {1'b0, step_l};
  assign up = sum > {1'b0, MAXV} ? MAXV : sum[BITS-1:0];
  assign down = duty > step_l ? duty - step_l : '0;
  assign step_in = step == '0 ? BITS'(1) : step;
  assign hold_end = hold_cnt == hold_l;
  always_comb begin
    state_n = state;
    duty_n = duty;
    step_l_n = step_l;
    hold_l_n = hold_l;
    hold_cnt_n = hold_cnt;
    ch_sel_n = ch_sel;
    done_n = 1'b0;
    stop_p_n = stop_p | (busy & stop);
    case (state)
      IDLE: if (start && !stop) begin
        state_n = RAMP_UP;
        step_l_n = step_in;
        hold_l_n = hold;
      end
      RAMP_UP: if (tick) begin
        duty_n = up;
        if (up == MAXV) begin
          state_n = HOLD_HI;
          hold_cnt_n = '0;
        end
      end
      HOLD_HI: if (tick) begin
        state_n = hold_end ? RAMP_DOWN : HOLD_HI;
        hold_cnt_n = hold_end ? hold_cnt : hold_cnt + 1'b1;
      end
      RAMP_DOWN: if (tick) begin
        duty_n = down;
        if (down == '0) begin
          state_n = HOLD_LO;
          hold_cnt_n = '0;
        end
      end
      HOLD_LO: if (tick) begin
        if (hold_end) begin
          done_n = 1'b1;
          ch_sel_n = {ch_sel[NUM_CH-2:0], ch_sel[NUM_CH-1]};
          if (stop_p) begin
            state_n = IDLE;
            stop_p_n = 1'b0;
          end else begin
            state_n = RAMP_UP;
            step_l_n = step_in;
            hold_l_n = hold;
          end
        end else hold_cnt_n = hold_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty <= '0;
      step_l <= BITS'(1);
      hold_l <= '0;
      hold_cnt <= '0;
      ch_sel <= NUM_CH'(1);
      stop_p <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state <= state_n;
      duty <= duty_n;
      step_l <= step_l_n;
      hold_l <= hold_l_n;
      hold_cnt <= hold_cnt_n;
      ch_sel <= ch_sel_n;
      stop_p <= stop_p_n;
      cycle_done <= done_n;
    end
  end
endmodule
